tbl_arb: RTL and testbench
==========================

# tbl_arb

Sequencer and arbiter for the shared 320×68-bit FP seed/mask lookup table (`tblD`). Owns the table's single read/write port:
- streams table contents in from a load channel after reset or on demand;
- round-robin arbitrates lookups between two requesters (divide/sqrt front-ends);
- returns registered results tagged for each requester.

Sits between the FP divide/sqrt issue logic and `tblD`.

## Interface
Parameters:
- `NENT`, 320, number of table entries written per full load (address range 0..NENT-1).
- `TAGW`, 4, width of requester tag.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `req0_vld`, `req1_vld`  in  1  lookup request valid.
- `req0_rdy`, `req1_rdy`  out  1  request accepted this cycle (grant).
- `req0_A`, `req1_A`  in  68  lookup operand (FP68 format).
- `req0_xtra`, `req1_xtra`  in  3  lookup mode select.
- `req0_tag`, `req1_tag`  in  TAGW  request tag.
- `rsp0_vld`, `rsp1_vld`  out  1  response valid; no backpressure.
- `rsp0_data`, `rsp1_data`  out  68  table result.
- `rsp0_tag`, `rsp1_tag`  out  TAGW  echoed tag.
- `ld_start`  in  1  pulse: begin (re)load at address 0.
- `ld_vld`  in  1  load word valid.
- `ld_rdy`  out  1  load word accepted.
- `ld_data`  in  68  load word.
- `ld_last`  in  1  final load word.
- `tbl_A`  out  68  to `tblD` A.
- `tbl_B`  out  68  to `tblD` B; only [53:45] driven (write address), rest 0.
- `tbl_xtra`  out  3  to `tblD` xtra.
- `tbl_is_read`, `tbl_is_write`  out  1  `tblD` strobes.
- `tbl_res`  in  68  `tblD` combinational result.
- `tbl_ready`  out  1  table holds a completed load.
- `perf_grant0`, `perf_grant1`, `perf_conflict`  out  16  performance counters.

## Operation
- FSM states: EMPTY, LOAD, READY. Reset → EMPTY.
- EMPTY → LOAD on `ld_start`. READY → LOAD on `ld_start`. LOAD on `ld_start` restarts: counter returns to 0 and previously written words are kept but overwritten as reload proceeds.
- LOAD behaviour:
  - `ld_rdy`=1, both `reqN_rdy`=0.
  - A word is written on `ld_vld`&`ld_rdy`: `tbl_is_write`=1, `tbl_A`=`ld_data`, `tbl_B[53:45]`=9-bit address counter; the counter then increments.
  - LOAD → READY after writing a word with `ld_last`=1 or at address NENT-1, whichever comes first. Words past an early `ld_last` keep stale contents. The counter never wraps.
- READY behaviour:
  - `ld_rdy`=0, `tbl_ready`=1.
  - Requests are arbitrated; one grant per cycle.
  - The granted request drives `tbl_is_read`=1, `tbl_A`, and `tbl_xtra`.
  - `tbl_res` and the tag are captured into that requester's response register.
- Arbitration: a single valid requester wins. When both are valid, the one not granted most recently wins. The priority pointer resets to favour req0 and updates only on a grant.
- `tbl_is_read` and `tbl_is_write` are never both 1.
- `ld_start` in the same cycle as a READY grant: the grant completes and its response is delivered; LOAD begins next cycle.
- `ld_vld` outside LOAD is ignored.
- An asynchronous reset mid-load returns to EMPTY with `tbl_ready`=0; table contents are treated as invalid.

## Timing
- Reset values: all `rdy`/`vld`/strobe outputs 0, `tbl_ready`=0, data/tag outputs 0, `tbl_A`/`tbl_B`/`tbl_xtra` 0, counters 0.
- Grant is combinational from `reqN_vld` and state. The response is registered, so `rspN_vld` pulses exactly 1 cycle after `reqN_rdy`. A back-to-back requester receives one response per cycle.
- Each write commits at the clock edge that accepts the word; `tbl_ready` rises the cycle after the final write.
- Load throughput: 1 word/cycle. A full 320-word load takes 320 accepted cycles.

## Configuration
- Macro `TBL_ARB_PERF_EN`.
- Defined:
  - `perf_grant0` and `perf_grant1` count grants.
  - `perf_conflict` counts cycles with both `reqN_vld`=1 while in READY.
  - All three are 16-bit saturating at 16'hFFFF, cleared by reset and by `ld_start`.
- Undefined: counters are not built; the three ports are tied to 0.

## Test plan
- Reset, `ld_start`, 320 words with `ld_data`=address, `ld_last` on the last word -> 320 writes with `tbl_B[53:45]`=0..319; `tbl_ready`=1 on the cycle after word 319; no grant during the load.
- After load, `req0_vld`=1 alone with tag 4'h3 -> `req0_rdy`=1; next cycle `rsp0_vld`=1, `rsp0_tag`=4'h3, `rsp0_data`=the `tbl_res` value sampled at grant.
- Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1; `perf_conflict`=6 and `perf_grant0`=`perf_grant1`=3 with `TBL_ARB_PERF_EN`; the perf ports read 0 without it.
- `ld_last` on word 100 -> READY after 101 writes; a later `ld_start` with the stream stalled for 5 cycles keeps `tbl_ready`=0 and both `reqN_rdy`=0 throughout.
- Reset asserted at word 50 of a load -> all outputs 0 immediately, state EMPTY, `tbl_ready`=0; `ld_vld` is ignored until the next `ld_start`.
- `ld_start` on the same cycle as a req1 grant -> `rsp1_vld`=1 on the next cycle; `ld_rdy`=1 from the next cycle.

Source files
------------

// File: rtl/tbl_arb.sv
// tbl_arb: sequencer/arbiter owning the single port of the FP seed/mask table.
// Latency: grant is combinational; response registered one cycle after grant; one load word per cycle.
// Backpressure: requests are held off (rdy=0) outside READY; responses have none; ld_rdy only in LOAD.
//
// Ports: clk/rst (async active-low); req0/req1 lookup channels (vld/rdy, A, xtra, tag);
// rsp0/rsp1 registered results with echoed tag; ld_* load stream; tbl_* table port;
// tbl_ready status; perf_* counters (built only when TBL_ARB_PERF_EN is defined, else tied 0).
module tbl_arb #(
    parameter int NENT = 320,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_vld,
    input  logic            req1_vld,
    output logic            req0_rdy,
    output logic            req1_rdy,
    input  logic [67:0]     req0_A,
    input  logic [67:0]     req1_A,
    input  logic [2:0]      req0_xtra,
    input  logic [2:0]      req1_xtra,
    input  logic [TAGW-1:0] req0_tag,
    input  logic [TAGW-1:0] req1_tag,
    output logic            rsp0_vld,
    output logic            rsp1_vld,
    output logic [67:0]     rsp0_data,
    output logic [67:0]     rsp1_data,
    output logic [TAGW-1:0] rsp0_tag,
    output logic [TAGW-1:0] rsp1_tag,
    input  logic            ld_start,
    input  logic            ld_vld,
    output logic            ld_rdy,
    input  logic [67:0]     ld_data,
    input  logic            ld_last,
    output logic [67:0]     tbl_A,
    output logic [67:0]     tbl_B,
    output logic [2:0]      tbl_xtra,
    output logic            tbl_is_read,
    output logic            tbl_is_write,
    input  logic [67:0]     tbl_res,
    output logic            tbl_ready,
    output logic [15:0]     perf_grant0,
    output logic [15:0]     perf_grant1,
    output logic [15:0]     perf_conflict
);

    typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [8:0]      r_addr;
    logic            r_prio1;      // 1: req1 wins the next conflict
    logic            w_grant0;
    logic            w_grant1;
    logic            w_wr;
    logic            w_wr_final;

    logic            r_rsp0_vld, r_rsp1_vld;
    logic [67:0]     r_rsp0_data, r_rsp1_data;
    logic [TAGW-1:0] r_rsp0_tag, r_rsp1_tag;

    assign w_wr       = (r_state == ST_LOAD) && ld_vld;
    assign w_wr_final = w_wr && (ld_last || (r_addr == 9'(NENT - 1)));
    assign w_grant0   = (r_state == ST_READY) && req0_vld && (!req1_vld || !r_prio1);
    assign w_grant1   = (r_state == ST_READY) && req1_vld && (!req0_vld || r_prio1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ld_start always (re)enters LOAD; in READY the same-cycle grant still completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (ld_start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (ld_start)        w_state_nxt = ST_LOAD;
                else if (w_wr_final) w_state_nxt = ST_READY;
            end
            ST_READY: if (ld_start) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // The write address stops after the final word, so it never wraps past NENT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_prio1 <= 1'b0;
        end else begin
            if (ld_start)  r_addr <= '0;
            else if (w_wr) r_addr <= r_addr + 9'd1;
            if (w_grant0)      r_prio1 <= 1'b1;
            else if (w_grant1) r_prio1 <= 1'b0;
        end
    end

    always_comb begin
        tbl_A    = '0;
        tbl_B    = '0;
        tbl_xtra = '0;
        if (w_wr) begin
            tbl_A        = ld_data;
            tbl_B[53:45] = r_addr;
        end else if (w_grant0) begin
            tbl_A    = req0_A;
            tbl_xtra = req0_xtra;
        end else if (w_grant1) begin
            tbl_A    = req1_A;
            tbl_xtra = req1_xtra;
        end
    end

    assign tbl_is_write = w_wr;
    assign tbl_is_read  = w_grant0 | w_grant1;
    assign req0_rdy     = w_grant0;
    assign req1_rdy     = w_grant1;
    assign ld_rdy       = (r_state == ST_LOAD);
    assign tbl_ready    = (r_state == ST_READY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp0_vld  <= 1'b0;
            r_rsp1_vld  <= 1'b0;
            r_rsp0_data <= '0;
            r_rsp1_data <= '0;
            r_rsp0_tag  <= '0;
            r_rsp1_tag  <= '0;
        end else begin
            r_rsp0_vld <= w_grant0;
            r_rsp1_vld <= w_grant1;
            if (w_grant0) begin
                r_rsp0_data <= tbl_res;
                r_rsp0_tag  <= req0_tag;
            end
            if (w_grant1) begin
                r_rsp1_data <= tbl_res;
                r_rsp1_tag  <= req1_tag;
            end
        end
    end

    assign rsp0_vld  = r_rsp0_vld;
    assign rsp1_vld  = r_rsp1_vld;
    assign rsp0_data = r_rsp0_data;
    assign rsp1_data = r_rsp1_data;
    assign rsp0_tag  = r_rsp0_tag;
    assign rsp1_tag  = r_rsp1_tag;

`ifdef TBL_ARB_PERF_EN
    logic [15:0] r_pg0, r_pg1, r_pcf;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ld_start clears even if a grant lands in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pg0 <= '0;
            r_pg1 <= '0;
            r_pcf <= '0;
        end else if (ld_start) begin
            r_pg0 <= '0;
            r_pg1 <= '0;
            r_pcf <= '0;
        end else begin
            if (w_grant0) r_pg0 <= sat_inc(r_pg0);
            if (w_grant1) r_pg1 <= sat_inc(r_pg1);
            if ((r_state == ST_READY) && req0_vld && req1_vld) r_pcf <= sat_inc(r_pcf);
        end
    end

    assign perf_grant0   = r_pg0;
    assign perf_grant1   = r_pg1;
    assign perf_conflict = r_pcf;
`else
    assign perf_grant0   = '0;
    assign perf_grant1   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_tbl_arb.sv
module tb_tbl_arb;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [67:0]     req0_A, req1_A;
    logic [2:0]      req0_xtra, req1_xtra;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic            rsp0_vld, rsp1_vld;
    logic [67:0]     rsp0_data, rsp1_data;
    logic [TAGW-1:0] rsp0_tag, rsp1_tag;
    logic            ld_start, ld_vld, ld_rdy, ld_last;
    logic [67:0]     ld_data;
    logic [67:0]     tbl_A, tbl_B, tbl_res;
    logic [2:0]      tbl_xtra;
    logic            tbl_is_read, tbl_is_write, tbl_ready;
    logic [15:0]     perf_grant0, perf_grant1, perf_conflict;

    tbl_arb #(.NENT(320), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req1_vld(req1_vld), .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
        .req0_A(req0_A), .req1_A(req1_A), .req0_xtra(req0_xtra), .req1_xtra(req1_xtra),
        .req0_tag(req0_tag), .req1_tag(req1_tag),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .rsp0_tag(rsp0_tag), .rsp1_tag(rsp1_tag),
        .ld_start(ld_start), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_data(ld_data), .ld_last(ld_last),
        .tbl_A(tbl_A), .tbl_B(tbl_B), .tbl_xtra(tbl_xtra),
        .tbl_is_read(tbl_is_read), .tbl_is_write(tbl_is_write), .tbl_res(tbl_res),
        .tbl_ready(tbl_ready),
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
    );

    always #5 clk = ~clk;

    // Stand-in for tblD: a combinational function of the lookup operand and mode.
    function automatic logic [67:0] mix(input logic [67:0] a, input logic [2:0] x);
        return {a[33:0], a[67:34]} ^ {65'h0, x} ^ 68'hF_0F01_2345_6789_ABCD;
    endfunction
    assign tbl_res = tbl_is_read ? mix(tbl_A, tbl_xtra) : 68'h0;

    int n_vec = 0;
    int n_err = 0;

    // pending responses expected on the next cycle
    logic            p0 = 1'b0, p1 = 1'b0;
    logic [67:0]     p0d = '0, p1d = '0;
    logic [TAGW-1:0] p0t = '0, p1t = '0;
    // reference perf counts since the last ld_start
    int m_g0 = 0, m_g1 = 0, m_cf = 0;

    typedef struct {
        logic v0, v1, e0, e1;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [67:0] rnd68();
        return {4'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {ld_rdy, req0_rdy, req1_rdy, rsp0_vld, rsp1_vld,
                           tbl_is_read, tbl_is_write, tbl_ready}, 0);
        chk({nm, "_tblA"}, tbl_A, 0);
        chk({nm, "_tblB"}, tbl_B, 0);
        chk({nm, "_xtra"}, tbl_xtra, 0);
        chk({nm, "_rspdat"}, rsp0_data | rsp1_data, 0);
        chk({nm, "_rsptag"}, {rsp0_tag, rsp1_tag}, 0);
        chk({nm, "_perf"}, {perf_grant0, perf_grant1, perf_conflict}, 0);
    endtask

    task automatic chk_perf(input string nm);
        int e0, e1, ec;
`ifdef TBL_ARB_PERF_EN
        e0 = (m_g0 > 65535) ? 65535 : m_g0;
        e1 = (m_g1 > 65535) ? 65535 : m_g1;
        ec = (m_cf > 65535) ? 65535 : m_cf;
`else
        e0 = 0; e1 = 0; ec = 0;
`endif
        chk({nm, "_perf_grant0"}, perf_grant0, 68'(e0));
        chk({nm, "_perf_grant1"}, perf_grant1, 68'(e1));
        chk({nm, "_perf_conflict"}, perf_conflict, 68'(ec));
    endtask

    // One READY cycle: drive requests, check the grant against e0/e1 and the
    // response scheduled by the previous cycle.
    task automatic rcycle(input logic v0, input logic v1, input logic e0, input logic e1,
                          input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1);
        logic [67:0] a0, a1;
        logic [2:0]  x0, x1;
        a0 = rnd68(); a1 = rnd68();
        x0 = 3'($urandom()); x1 = 3'($urandom());
        req0_vld = v0; req0_A = a0; req0_xtra = x0; req0_tag = t0;
        req1_vld = v1; req1_A = a1; req1_xtra = x1; req1_tag = t1;
        #4;
        chk("rsp0_vld", rsp0_vld, p0);
        chk("rsp1_vld", rsp1_vld, p1);
        if (p0) begin
            chk("rsp0_data", rsp0_data, p0d);
            chk("rsp0_tag", rsp0_tag, p0t);
        end
        if (p1) begin
            chk("rsp1_data", rsp1_data, p1d);
            chk("rsp1_tag", rsp1_tag, p1t);
        end
        chk("req_rdy", {req0_rdy, req1_rdy}, {e0, e1});
        chk("strobes", {tbl_is_read, tbl_is_write}, {e0 | e1, 1'b0});
        if (e0 | e1) begin
            chk("tbl_A_rd", tbl_A, e0 ? a0 : a1);
            chk("tbl_xtra_rd", tbl_xtra, e0 ? x0 : x1);
        end
        p0 = e0; p0d = mix(a0, x0); p0t = t0;
        p1 = e1; p1d = mix(a1, x1); p1t = t1;
        if (e0) m_g0++;
        if (e1) m_g1++;
        if (v0 && v1) m_cf++;
        nxt();
    endtask

    // ld_start pulse, then n words (data = address) with ld_last at last_at,
    // requests held valid throughout, then one extra offered word.
    task automatic load(input int n, input int last_at);
        req0_vld = 1'b0; req1_vld = 1'b0;
        ld_start = 1'b1; ld_vld = 1'b0; ld_last = 1'b0;
        nxt();
        ld_start = 1'b0;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
        for (int i = 0; i < n; i++) begin
            ld_vld = 1'b1; ld_data = 68'(i); ld_last = (i == last_at);
            req0_vld = 1'b1; req1_vld = 1'b1;
            #4;
            chk("ld_wr", tbl_is_write, 1);
            chk("ld_addr", tbl_B, 68'(i) << 45);
            chk("ld_A", tbl_A, 68'(i));
            chk("ld_ctl", {ld_rdy, req0_rdy, req1_rdy, tbl_is_read, tbl_ready}, 5'b10000);
            nxt();
        end
        ld_vld = 1'b1; ld_last = 1'b0; ld_data = 68'h123;
        req0_vld = 1'b0; req1_vld = 1'b0;
        #4;
        chk("ld_done", {tbl_ready, ld_rdy, tbl_is_write}, 3'b100);
        nxt();
        ld_vld = 1'b0;
        p0 = 1'b0; p1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int g;
        logic v0, v1;

        vecs[0] = '{v0:0, v1:0, e0:0, e1:0};
        vecs[1] = '{v0:0, v1:1, e0:0, e1:1};
        vecs[2] = '{v0:1, v1:1, e0:1, e1:0};
        vecs[3] = '{v0:1, v1:1, e0:0, e1:1};
        vecs[4] = '{v0:1, v1:0, e0:1, e1:0};
        vecs[5] = '{v0:1, v1:1, e0:0, e1:1};
        vecs[6] = '{v0:0, v1:0, e0:0, e1:0};
        vecs[7] = '{v0:1, v1:1, e0:1, e1:0};
        vecs[8] = '{v0:0, v1:1, e0:0, e1:1};
        vecs[9] = '{v0:1, v1:1, e0:1, e1:0};

        rst = 1'b0;
        req0_vld = 1'b1; req1_vld = 1'b0;
        req0_A = rnd68(); req1_A = '0; req0_xtra = 3'd5; req1_xtra = '0;
        req0_tag = 4'h7; req1_tag = '0;
        ld_start = 1'b0; ld_vld = 1'b1; ld_last = 1'b0; ld_data = 68'h55;
        #2;
        chk_all_zero("reset");
        nxt();
        rst = 1'b1;
        req0_vld = 1'b0; ld_vld = 1'b0;
        nxt();
        #4;
        chk_all_zero("empty");
        nxt();

        // full 320-word load
        load(320, 319);

        // six-cycle conflict: grants alternate starting with req0
        for (int i = 0; i < 6; i++) rcycle(1'b1, 1'b1, (i % 2) == 0, (i % 2) == 1,
                                           4'($urandom()), 4'($urandom()));
        rcycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk_perf("conflict6");

        // req0 alone with tag 3
        rcycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h9);
        rcycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        // arbitration table
        for (int i = 0; i < 10; i++)
            rcycle(vecs[i].v0, vecs[i].v1, vecs[i].e0, vecs[i].e1,
                   4'($urandom()), 4'($urandom()));
        rcycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk_perf("table");

        // randomized traffic against the round-robin reference
        rcycle(1'b0, 1'b1, 1'b0, 1'b1, 4'($urandom()), 4'($urandom()));
        last = 1;
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            if (v0 && !v1)      g = 0;
            else if (v1 && !v0) g = 1;
            else if (v0 && v1)  g = 1 - last;
            else                g = -1;
            if (g >= 0) last = g;
            rcycle(v0, v1, g == 0, g == 1, 4'($urandom()), 4'($urandom()));
        end
        rcycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        chk_perf("random");

        // early ld_last on word 100
        load(101, 100);

        // reload with the stream stalled for 5 cycles
        ld_start = 1'b1;
        nxt();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req0_vld = 1'b1; req1_vld = 1'b1; ld_vld = 1'b0;
            #4;
            chk("stall", {tbl_ready, req0_rdy, req1_rdy, ld_rdy, tbl_is_write}, 5'b00010);
            nxt();
        end
        req0_vld = 1'b0; req1_vld = 1'b0;

        // 50 words, then reset asserted while word 50 is offered
        for (int i = 0; i < 50; i++) begin
            ld_vld = 1'b1; ld_data = 68'(i); ld_last = 1'b0;
            #4;
            chk("pre_rst_wr", {tbl_is_write, tbl_B}, {1'b1, 68'(i) << 45});
            nxt();
        end
        ld_data = 68'd50;
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("mid_load_reset");
        nxt();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_vld = 1'b1; ld_data = 68'(i + 1000);
            #4;
            chk("ignored_ld", {ld_rdy, tbl_is_write, tbl_ready}, 3'b000);
            nxt();
        end
        ld_vld = 1'b0;

        // short load, then ld_start coinciding with a req1 grant
        load(10, 9);
        ld_start = 1'b1;
        rcycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hA);
        ld_start = 1'b0;
        req1_vld = 1'b0;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
        #4;
        chk("start_grant_rsp1_vld", rsp1_vld, 1);
        chk("start_grant_rsp1_data", rsp1_data, p1d);
        chk("start_grant_rsp1_tag", rsp1_tag, 4'hA);
        chk("start_grant_ld_rdy", {ld_rdy, tbl_ready}, 2'b10);
        chk_perf("start_grant");
        nxt();
        #4;
        chk("start_grant_rsp1_drop", rsp1_vld, 0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
